// File: rtl/tile_mem_arbiter.sv
// Single-port tile map arbiter: render reads, paint writes, BFS access
// and a built-in map clear engine, with starvation-bounded draw priority.
module tile_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              paint_req,
  input  logic [ADDR_W-1:0] paint_addr,
  input  logic [DATA_W-1:0] paint_wdata,
  output logic              paint_gnt,
  input  logic              alg_req,
  input  logic              alg_we,
  input  logic [ADDR_W-1:0] alg_addr,
  input  logic [DATA_W-1:0] alg_wdata,
  output logic              alg_gnt,
  output logic              alg_rvalid,
  output logic [DATA_W-1:0] alg_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DRAW = 2'd1,
    TAG_ALG  = 2'd2
  } tag_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_BUSY = 1'b1
  } clr_state_e;

  clr_state_e        clr_st_q, clr_st_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_done_q, clr_done_d;
  logic              rr_q, rr_d;
  tag_e              tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     p_cnt_q, p_cnt_d;
  logic [CW-1:0]     a_cnt_q, a_cnt_d;
  logic [CW-1:0]     c_cnt_q, c_cnt_d;

  logic busy;
  logic p_elig, a_elig;
  logic p_starve, a_starve, c_starve;
  logic g_draw, g_paint, g_alg, g_clr;

  function automatic logic [CW-1:0] wait_next(
    input logic [CW-1:0] cnt,
    input logic          pend,
    input logic          gnt
  );
    if (pend && !gnt)
      return (cnt == SMAX) ? cnt : cnt + 1'b1;
    return '0;
  endfunction

  assign busy     = (clr_st_q == CLR_BUSY);
  assign p_elig   = paint_req & ~busy;
  assign a_elig   = alg_req & ~busy;
  assign p_starve = p_elig & (p_cnt_q == SMAX);
  assign a_starve = a_elig & (a_cnt_q == SMAX);
  assign c_starve = busy & (c_cnt_q == SMAX);

  // rr_q=1 means alg won last, so paint takes the next contention
  always_comb begin
    g_draw  = 1'b0;
    g_paint = 1'b0;
    g_alg   = 1'b0;
    g_clr   = 1'b0;
    if (!Reset) begin
      if (c_starve) begin
        g_clr = 1'b1;
      end else if (p_starve && a_starve) begin
        g_paint = rr_q;
        g_alg   = ~rr_q;
      end else if (p_starve) begin
        g_paint = 1'b1;
      end else if (a_starve) begin
        g_alg = 1'b1;
      end else if (draw_req) begin
        g_draw = 1'b1;
      end else if (busy) begin
        g_clr = 1'b1;
      end else if (p_elig && a_elig) begin
        g_paint = rr_q;
        g_alg   = ~rr_q;
      end else if (p_elig) begin
        g_paint = 1'b1;
      end else if (a_elig) begin
        g_alg = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = g_paint | g_clr | (g_alg & alg_we);
    mem_re    = g_draw | (g_alg & ~alg_we);
    mem_addr  = addr_q;
    mem_wdata = '0;
    unique case (1'b1)
      g_draw:  mem_addr = draw_addr;
      g_paint: mem_addr = paint_addr;
      g_alg:   mem_addr = alg_addr;
      g_clr:   mem_addr = clr_addr_q;
      default: mem_addr = addr_q;
    endcase
    if (g_paint)
      mem_wdata = paint_wdata;
    else if (g_alg && alg_we)
      mem_wdata = alg_wdata;
  end

  always_comb begin
    p_cnt_d = wait_next(p_cnt_q, paint_req, g_paint);
    a_cnt_d = wait_next(a_cnt_q, alg_req, g_alg);
    c_cnt_d = wait_next(c_cnt_q, busy, g_clr);
    rr_d    = rr_q;
    if (g_paint)
      rr_d = 1'b0;
    else if (g_alg)
      rr_d = 1'b1;
    tag_d = TAG_NONE;
    if (g_draw)
      tag_d = TAG_DRAW;
    else if (g_alg && !alg_we)
      tag_d = TAG_ALG;
  end

  always_comb begin
    clr_st_d   = clr_st_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = 1'b0;
    unique case (clr_st_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_st_d   = CLR_BUSY;
          clr_addr_d = '0;
        end
      end
      CLR_BUSY: begin
        if (g_clr) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            clr_st_d   = CLR_IDLE;
            clr_done_d = 1'b1;
          end
        end
      end
      default: clr_st_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      clr_st_q   <= CLR_IDLE;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
      rr_q       <= 1'b1;
      tag_q      <= TAG_NONE;
      addr_q     <= '0;
      p_cnt_q    <= '0;
      a_cnt_q    <= '0;
      c_cnt_q    <= '0;
    end else begin
      clr_st_q   <= clr_st_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
      rr_q       <= rr_d;
      tag_q      <= tag_d;
      addr_q     <= mem_addr;
      p_cnt_q    <= p_cnt_d;
      a_cnt_q    <= a_cnt_d;
      c_cnt_q    <= c_cnt_d;
    end
  end

  assign draw_gnt    = g_draw;
  assign paint_gnt   = g_paint;
  assign alg_gnt     = g_alg;
  assign draw_rvalid = (tag_q == TAG_DRAW);
  assign alg_rvalid  = (tag_q == TAG_ALG);
  assign draw_rdata  = mem_rdata;
  assign alg_rdata   = mem_rdata;
  assign clr_busy    = busy;
  assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed bench for tile_mem_arbiter with a 1-cycle-latency OCM model.
// Expected values are hand-derived per vector.
module tb_tile_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_req;
  logic [11:0] draw_addr;
  logic        draw_gnt, draw_rvalid;
  logic [7:0]  draw_rdata;
  logic        paint_req;
  logic [11:0] paint_addr;
  logic [7:0]  paint_wdata;
  logic        paint_gnt;
  logic        alg_req, alg_we;
  logic [11:0] alg_addr;
  logic [7:0]  alg_wdata;
  logic        alg_gnt, alg_rvalid;
  logic [7:0]  alg_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem [0:4095];

  int n_run  = 0;
  int n_fail = 0;

  tile_mem_arbiter dut (
    .CLOCK_50    (clk),
    .Reset       (rst),
    .draw_req    (draw_req),
    .draw_addr   (draw_addr),
    .draw_gnt    (draw_gnt),
    .draw_rvalid (draw_rvalid),
    .draw_rdata  (draw_rdata),
    .paint_req   (paint_req),
    .paint_addr  (paint_addr),
    .paint_wdata (paint_wdata),
    .paint_gnt   (paint_gnt),
    .alg_req     (alg_req),
    .alg_we      (alg_we),
    .alg_addr    (alg_addr),
    .alg_wdata   (alg_wdata),
    .alg_gnt     (alg_gnt),
    .alg_rvalid  (alg_rvalid),
    .alg_rdata   (alg_rdata),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, errs, pg, nz;
    for (int i = 0; i < 4096; i++) mem[i] <= 8'h11;
    mem[12'h0A5] <= 8'h04;
    mem[12'h010] <= 8'h02;

    rst = 1'b1;
    draw_req = 1'b1; draw_addr = 12'h123;
    paint_req = 1'b1; paint_addr = 12'h456; paint_wdata = 8'h04;
    alg_req = 1'b1; alg_we = 1'b1; alg_addr = 12'h789; alg_wdata = 8'h01;
    clr_start = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_draw_gnt", draw_gnt, 0);
    chk("rst_paint_gnt", paint_gnt, 0);
    chk("rst_alg_gnt", alg_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_rvalids", {draw_rvalid, alg_rvalid}, 0);
    draw_req = 0; paint_req = 0; alg_req = 0; clr_start = 0;
    step();
    rst = 1'b0;
    #1;
    chk("idle_gnts", {draw_gnt, paint_gnt, alg_gnt}, 0);
    chk("idle_we_re", {mem_we, mem_re}, 0);
    step();
    chk("idle2_we_re", {mem_we, mem_re}, 0);
    chk("idle2_busy", clr_busy, 0);

    draw_req = 1; draw_addr = 12'h0A5;
    #1;
    chk("draw_gnt", draw_gnt, 1);
    chk("draw_mem_re", mem_re, 1);
    chk("draw_mem_addr", mem_addr, 12'h0A5);
    step();
    draw_req = 0;
    #1;
    chk("draw_rvalid", draw_rvalid, 1);
    chk("draw_rdata", draw_rdata, 8'h04);
    step();
    chk("draw_rvalid_off", draw_rvalid, 0);
    chk("idle_addr_hold", mem_addr, 12'h0A5);
    chk("idle_addr_we_re", {mem_we, mem_re}, 0);

    paint_req = 1; paint_addr = 12'h020; paint_wdata = 8'h04;
    alg_req = 1; alg_we = 0; alg_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_paint%0d", i), paint_gnt, (i % 2 == 0));
      chk($sformatf("rr_alg%0d", i), alg_gnt, (i % 2 == 1));
      if (i > 0) chk($sformatf("rr_rvalid%0d", i), alg_rvalid, (i % 2 == 0));
      step();
    end
    paint_req = 0; alg_req = 0;
    #1;
    chk("rr_rvalid_last", alg_rvalid, 1);
    chk("rr_rdata", alg_rdata, 8'h02);
    chk("paint_written", mem[12'h020], 8'h04);
    step();

    draw_req = 1; draw_addr = 12'h0A5;
    alg_req = 1; alg_we = 0; alg_addr = 12'h010;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("stv_draw%0d", c), draw_gnt, 1);
      chk($sformatf("stv_alg%0d", c), alg_gnt, 0);
      step();
    end
    #1;
    chk("stv9_alg", alg_gnt, 1);
    chk("stv9_draw", draw_gnt, 0);
    chk("stv9_addr", mem_addr, 12'h010);
    step();
    alg_req = 0;
    #1;
    chk("stv10_draw", draw_gnt, 1);
    chk("stv10_rvalid", alg_rvalid, 1);
    chk("stv10_rdata", alg_rdata, 8'h02);
    step();
    draw_req = 0;
    #1;
    chk("stv11_rvalid", draw_rvalid, 1);
    chk("stv11_rdata", draw_rdata, 8'h04);
    step();

    clr_start = 1;
    #1;
    chk("clr_pre_busy", clr_busy, 0);
    step();
    clr_start = 0;
    paint_req = 1; paint_addr = 12'h030; paint_wdata = 8'h04;
    k = 0; errs = 0; pg = 0;
    while (clr_busy && k < 5000) begin
      clr_start = (k == 2000);
      #1;
      if (!(mem_we && !mem_re && mem_addr == 12'(k) && mem_wdata == 8'h00))
        errs++;
      if (paint_gnt) pg++;
      step();
      k++;
    end
    clr_start = 0;
    #1;
    chk("clr_cycles", k, 4096);
    chk("clr_write_errs", errs, 0);
    chk("clr_paint_gnts", pg, 0);
    chk("clr_done_pulse", clr_done, 1);
    chk("clr_busy_off", clr_busy, 0);
    chk("clr_paint_after", paint_gnt, 1);
    chk("clr_paint_addr", mem_addr, 12'h030);
    step();
    paint_req = 0;
    #1;
    chk("clr_done_1cyc", clr_done, 0);
    nz = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] != 8'h00) nz++;
    chk("clr_nonzero", nz, 1);
    chk("clr_paint_val", mem[12'h030], 8'h04);
    step();

    clr_start = 1;
    step();
    clr_start = 0;
    k = 0;
    while (mem_addr != 12'd100 && k < 200) begin
      step();
      k++;
    end
    chk("abort_addr", mem_addr, 12'd100);
    rst = 1;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_we", mem_we, 0);
    step();
    rst = 0;
    #1;
    chk("abort_no_done", clr_done, 0);
    step();
    chk("abort_no_done2", clr_done, 0);
    chk("abort_idle_we", mem_we, 0);
    clr_start = 1;
    step();
    clr_start = 0;
    #1;
    chk("restart_busy", clr_busy, 1);
    chk("restart_addr", mem_addr, 0);
    chk("restart_we", mem_we, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
